// File: rtl/vout_sinepwm_multi.sv
`timescale 1ns/1ps
// vout_sinepwm_multi: multi-phase sine-modulated PWM generator.
// A DDS phase accumulator advances once per carrier period. Each channel reads a
// full-wave sine table at an evenly spaced phase offset, scales the sample by
// 'amplitude' and drives complementary gate outputs with dead time.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   enable     1 = run; 0 = outputs low, phase held, duty tracks the held phase
//   freq       signed phase increment applied at each carrier period boundary
//   amplitude  modulation depth (0 = flat 50 %, all ones = full scale)
//   pwm_hi     registered high-side gate per channel
//   pwm_lo     registered low-side gate per channel
module vout_sinepwm_multi #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned TABLE_BITS = 5,
   parameter int unsigned DEADTIME   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic signed [31:0]         freq,
   input  logic        [PWM_BITS-1:0] amplitude,
   output logic        [CHANNELS-1:0] pwm_hi,
   output logic        [CHANNELS-1:0] pwm_lo
);

   localparam int unsigned PH_W  = 32;
   localparam int unsigned P     = (2 ** PWM_BITS) - 1;
   localparam int unsigned M     = 2 ** (PWM_BITS - 1);
   localparam int unsigned TBL_N = 2 ** TABLE_BITS;
   localparam int unsigned XW    = 2 * PWM_BITS + 1;
   localparam logic [63:0] OFF_STEP = (64'd1 << PH_W) / 64'(CHANNELS);
   localparam real         PI       = 3.14159265358979323846;

   logic        [PH_W-1:0]                    phase_q, phase_d;
   logic        [PWM_BITS-1:0]                cnt_q, cnt_d;
   logic        [CHANNELS-1:0][PWM_BITS-1:0]  duty_q, duty_d;
   logic        [CHANNELS-1:0][PWM_BITS-1:0]  dt_q, dt_d;
   logic        [CHANNELS-1:0]                raw_prev_q, raw_prev_d;
   logic        [CHANNELS-1:0]                hi_q, hi_d;
   logic        [CHANNELS-1:0]                lo_q, lo_d;
   logic        [CHANNELS-1:0][PWM_BITS-1:0]  duty_calc;
   logic        [CHANNELS-1:0]                raw;
   logic        [PH_W-1:0]                    ph_k;
   logic signed [PWM_BITS-1:0]                sine_tbl [TBL_N];

   // Sine table sampled at bin centres so the wave is symmetric with no zero entries.
   for (genvar gi = 0; gi < TBL_N; gi++) begin : g_sine
      localparam real ANG = 2.0 * PI * (real'(gi) + 0.5) / real'(TBL_N);
      localparam int  SV  = int'(real'(M - 1) * $sin(ANG));
      assign sine_tbl[gi] = PWM_BITS'(SV);
   end

   // duty = M + floor(sample * amp / 2^PWM_BITS); signed product so the shift floors.
   function automatic logic [PWM_BITS-1:0] scale_duty(input logic signed [PWM_BITS-1:0] s,
                                                      input logic        [PWM_BITS-1:0] amp);
      logic signed [XW-1:0] prod;
      prod = XW'(s) * $signed(XW'(amp));
      return PWM_BITS'($signed(XW'(M)) + (prod >>> PWM_BITS));
   endfunction

   // Candidate duty per channel from the current phase plus its fixed offset.
   always_comb begin : duty_calc_comb
      duty_calc = '0;
      ph_k      = '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         ph_k         = phase_q + PH_W'(64'(k) * OFF_STEP);
         duty_calc[k] = scale_duty(sine_tbl[ph_k[PH_W-1 -: TABLE_BITS]], amplitude);
      end
   end

   // Carrier, period-boundary updates, dead-time insertion and output decode.
   always_comb begin : next_state
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      duty_d     = duty_q;
      dt_d       = dt_q;
      raw_prev_d = raw_prev_q;
      hi_d       = '0;
      lo_d       = '0;
      raw        = '0;
      if (!enable) begin
         // Clearing raw_prev forces a dead-time window at the first edge after enable.
         cnt_d      = '0;
         duty_d     = duty_calc;
         dt_d       = '0;
         raw_prev_d = '0;
      end else begin
         if (cnt_q == PWM_BITS'(P - 1)) begin
            cnt_d   = '0;
            duty_d  = duty_calc;
            phase_d = phase_q + $unsigned(freq);
         end else begin
            cnt_d = cnt_q + PWM_BITS'(1);
         end
         for (int k = 0; k < int'(CHANNELS); k++) begin
            raw[k] = (cnt_q < duty_q[k]);
            if (raw[k] != raw_prev_q[k]) begin
               dt_d[k] = PWM_BITS'(DEADTIME);
            end else if (dt_q[k] != '0) begin
               dt_d[k] = dt_q[k] - PWM_BITS'(1);
            end
            raw_prev_d[k] = raw[k];
            if (dt_d[k] == '0) begin
               hi_d[k] = raw[k];
               lo_d[k] = ~raw[k];
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin : regs
      if (reset) begin
         phase_q    <= '0;
         cnt_q      <= '0;
         duty_q     <= {CHANNELS{PWM_BITS'(M)}};
         dt_q       <= '0;
         raw_prev_q <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         dt_q       <= dt_d;
         raw_prev_q <= raw_prev_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign pwm_hi = hi_q;
   assign pwm_lo = lo_q;

endmodule

// File: tb/tb_vout_sinepwm_multi.sv
`timescale 1ns/1ps
// Bench for vout_sinepwm_multi: two instances (dead time 0 and 4) share stimulus.
// A period-level model predicts every output cycle; hand-computed on-time counts
// pin both the model and the design.
module tb_vout_sinepwm_multi;

   localparam int CH = 3;
   localparam int P  = 255;
   localparam int M  = 128;
   localparam real PI = 3.14159265358979323846;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic signed [31:0] freq = '0;
   logic        [7:0] amplitude = 8'd255;
   logic        [2:0] hi0, lo0, hi4, lo4;

   int vectors = 0;
   int errors  = 0;
   bit chk_on  = 1'b0;

   bit [31:0] m_phase;
   int        m_cnt;
   int        m_duty [CH];
   bit [2:0]  e_hi0, e_lo0, e_hi4, e_lo4;

   int h0 [CH], l0 [CH], h4 [CH], l4 [CH];

   int t2_hi [CH] = '{139, 239, 16};
   int t2_lo [CH] = '{116, 16, 239};
   int t6_hi0 [CH] = '{187, 208, 2};
   int t6_lo0 [CH] = '{68, 47, 253};
   int t6_hi4 [CH] = '{183, 204, 0};
   int t6_lo4 [CH] = '{64, 43, 249};

   vout_sinepwm_multi #(.CHANNELS(3), .PWM_BITS(8), .TABLE_BITS(5), .DEADTIME(0)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .freq(freq), .amplitude(amplitude),
      .pwm_hi(hi0), .pwm_lo(lo0));

   vout_sinepwm_multi #(.CHANNELS(3), .PWM_BITS(8), .TABLE_BITS(5), .DEADTIME(4)) u_dut4 (
      .clk(clk), .reset(reset), .enable(enable), .freq(freq), .amplitude(amplitude),
      .pwm_hi(hi4), .pwm_lo(lo4));

   always #5 clk = ~clk;

   // Duty for channel k at a given accumulator phase, straight from the sine formula.
   function automatic int duty_of(input bit [31:0] ph, input int k, input int amp);
      longint unsigned step;
      bit [31:0]       pk;
      int              idx;
      real             s;
      step = 64'h1_0000_0000 / CH;
      pk   = ph + 32'(step * longint'(k));
      idx  = int'(pk >> 27);
      s    = $floor(real'(M - 1) * $sin(2.0 * PI * (real'(idx) + 0.5) / 32.0) + 0.5);
      return M + int'($floor(s * real'(amp) / 256.0));
   endfunction

   // Model: outputs for carrier count c with duty d and dead time D are
   // hi = D <= c < d, lo = c >= d + D, visible one clock later.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= '0;
         m_cnt   <= 0;
         for (int k = 0; k < CH; k++) m_duty[k] <= M;
         e_hi0 <= '0; e_lo0 <= '0; e_hi4 <= '0; e_lo4 <= '0;
      end else if (!enable) begin
         m_cnt <= 0;
         for (int k = 0; k < CH; k++) m_duty[k] <= duty_of(m_phase, k, int'(amplitude));
         e_hi0 <= '0; e_lo0 <= '0; e_hi4 <= '0; e_lo4 <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            e_hi0[k] <= (m_cnt < m_duty[k]);
            e_lo0[k] <= (m_cnt >= m_duty[k]);
            e_hi4[k] <= (m_cnt >= 4) && (m_cnt < m_duty[k]);
            e_lo4[k] <= (m_cnt >= m_duty[k] + 4);
         end
         if (m_cnt == P - 1) begin
            m_cnt   <= 0;
            m_phase <= m_phase + $unsigned(freq);
            for (int k = 0; k < CH; k++) m_duty[k] <= duty_of(m_phase, k, int'(amplitude));
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   // Per-cycle compare against the model, plus the shoot-through check.
   always @(negedge clk) begin
      if (chk_on) begin
         vectors++;
         if ({hi0, lo0, hi4, lo4} !== {e_hi0, e_lo0, e_hi4, e_lo4}) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t: hi0=%b lo0=%b hi4=%b lo4=%b expected %b %b %b %b",
                     $time, hi0, lo0, hi4, lo4, e_hi0, e_lo0, e_hi4, e_lo4);
         end
         vectors++;
         if (((hi0 & lo0) | (hi4 & lo4)) != 3'b000) begin
            errors++;
            $display("FAIL shoot_through t=%0t: hi0&lo0=%b hi4&lo4=%b expected 000",
                     $time, hi0 & lo0, hi4 & lo4);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Count high cycles per channel over the next n clocks.
   task automatic measure(input int n);
      for (int k = 0; k < CH; k++) begin
         h0[k] = 0; l0[k] = 0; h4[k] = 0; l4[k] = 0;
      end
      repeat (n) begin
         @(negedge clk);
         for (int k = 0; k < CH; k++) begin
            h0[k] += int'(hi0[k]); l0[k] += int'(lo0[k]);
            h4[k] += int'(hi4[k]); l4[k] += int'(lo4[k]);
         end
      end
   endtask

   // Wait (bounded) until the next clock edge will process carrier count 'target'.
   task automatic wait_cnt(input int target);
      int n;
      n = 0;
      while (m_cnt != target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (m_cnt != target) begin
         vectors++;
         errors++;
         $display("FAIL wait_cnt: count %0d never reached, last %0d", target, m_cnt);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("reset_async_outputs", int'({hi0, lo0, hi4, lo4}), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int s;
      #1 reset = 1'b1;
      #1 chk_on = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("model_duty_ch0", duty_of(32'h0, 0, 255), 139);
      check("model_duty_ch1", duty_of(32'h0, 1, 255), 239);
      check("model_duty_ch2", duty_of(32'h0, 2, 255), 16);
      check("model_duty_min", duty_of(32'h1000_0000, 2, 255), 2);

      // Idle with enable low
      measure(1000);
      s = 0;
      for (int k = 0; k < CH; k++) s += h0[k] + l0[k] + h4[k] + l4[k];
      check("t1_idle_activity", s, 0);

      // Static vectors, full amplitude, phase 0
      enable = 1'b1;
      repeat (300) @(negedge clk);
      measure(20 * P);
      for (int k = 0; k < CH; k++) begin
         check($sformatf("t2_hi0_ch%0d", k), h0[k], 20 * t2_hi[k]);
         check($sformatf("t2_lo0_ch%0d", k), l0[k], 20 * t2_lo[k]);
      end

      // Zero amplitude: flat 50 % with dead time
      amplitude = 8'd0;
      repeat (300) @(negedge clk);
      measure(P);
      for (int k = 0; k < CH; k++) begin
         check($sformatf("t3_hi4_ch%0d", k), h4[k], 124);
         check($sformatf("t3_lo4_ch%0d", k), l4[k], 123);
         check($sformatf("t3_hi0_ch%0d", k), h0[k], 128);
         check($sformatf("t3_lo0_ch%0d", k), l0[k], 127);
      end

      // Rotation forward then reverse: one revolution sums every table entry once
      amplitude = 8'd255;
      freq = 32'sh0800_0000;
      repeat (600) @(negedge clk);
      measure(32 * P);
      for (int k = 0; k < CH; k++) begin
         check($sformatf("t4f_hi0_ch%0d", k), h0[k], 4080);
         check($sformatf("t4f_hi4_ch%0d", k), h4[k], 3956);
         check($sformatf("t4f_lo4_ch%0d", k), l4[k], 3956);
      end
      freq = 32'shF800_0000;
      repeat (600) @(negedge clk);
      measure(32 * P);
      for (int k = 0; k < CH; k++) begin
         check($sformatf("t4r_hi0_ch%0d", k), h0[k], 4080);
         check($sformatf("t4r_lo0_ch%0d", k), l0[k], 4080);
         check($sformatf("t4r_hi4_ch%0d", k), h4[k], 3956);
      end

      // Amplitude change mid-period takes effect at the next boundary only
      freq = '0;
      reset_pulse();
      repeat (600) @(negedge clk);
      wait_cnt(100);
      amplitude = 8'd0;
      measure(P - 100);
      check("t5_old_hi0_ch0", h0[0], 39);
      check("t5_old_lo0_ch0", l0[0], 116);
      check("t5_old_hi0_ch1", h0[1], 139);
      check("t5_old_lo0_ch1", l0[1], 16);
      check("t5_old_hi0_ch2", h0[2], 0);
      check("t5_old_lo0_ch2", l0[2], 155);
      measure(P);
      for (int k = 0; k < CH; k++) check($sformatf("t5_new_hi0_ch%0d", k), h0[k], 128);

      // Enable dropped mid-period after two boundaries; resume from frozen phase
      amplitude = 8'd255;
      freq = 32'sh0800_0000;
      reset_pulse();
      repeat (2 * P) @(negedge clk);
      wait_cnt(50);
      enable = 1'b0;
      @(negedge clk);
      check("t6_disabled_outputs", int'({hi0, lo0, hi4, lo4}), 0);
      repeat (19) @(negedge clk);
      enable = 1'b1;
      measure(P);
      for (int k = 0; k < CH; k++) begin
         check($sformatf("t6_hi0_ch%0d", k), h0[k], t6_hi0[k]);
         check($sformatf("t6_lo0_ch%0d", k), l0[k], t6_lo0[k]);
         check($sformatf("t6_hi4_ch%0d", k), h4[k], t6_hi4[k]);
         check($sformatf("t6_lo4_ch%0d", k), l4[k], t6_lo4[k]);
      end

      repeat (300) @(negedge clk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
